// File: rtl/ddr_pkg.sv
// Shared types and constants for the dance-game beat engine.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  // Lane encoding as seen on the controller and the arrow display
  localparam int LANE_UP    = 0;
  localparam int LANE_RIGHT = 1;
  localparam int LANE_LEFT  = 2;
  localparam int LANE_DOWN  = 3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Ticks per progress step for a given level, never below one tick
  function automatic int step_len_calc(input int level, input int base, input int dec);
    int len;
    len = base - level * dec;
    if (len < 1) len = 1;
    return len;
  endfunction

endpackage

// File: rtl/ddr_beat_engine_if.sv
// Player-side bus of the beat engine: controls and buttons in, cue/judgement/score out.
interface ddr_beat_engine_if #(
  parameter int NUM_LANES    = 4,
  parameter int PROG_W       = 16,
  parameter int SCORE_DIGITS = 2,
  parameter int COMBO_W      = 8
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                      run;
  logic [1:0]                level;
  logic [NUM_LANES-1:0]      btn;
  logic [LANE_W-1:0]         cue_lane;
  logic                      cue_valid;
  logic [PROG_W-1:0]         prog;
  logic                      hit;
  logic                      miss;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic [COMBO_W-1:0]        combo;

  modport master (
    output run, level, btn,
    input  cue_lane, cue_valid, prog, hit, miss, score_bcd, combo
  );

  modport slave (
    input  run, level, btn,
    output cue_lane, cue_valid, prog, hit, miss, score_bcd, combo
  );
endinterface

// File: rtl/ddr_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; wrap selects roll-over
// to zero versus holding at all nines.
module ddr_bcd_counter
  import ddr_pkg::*;
#(
  parameter int SCORE_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      clr,
  input  logic                      wrap,
  output logic [4*SCORE_DIGITS-1:0] value
);

  logic [SCORE_DIGITS:0] carry;

  // Ripple carry: digit i steps when every lower digit is at nine
  always_comb begin
    carry    = '0;
    carry[0] = inc;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      carry[i+1] = carry[i] && (value[4*i +: 4] == BCD_MAX);
    end
  end

  // Digit registers; a full-scale carry out only clears when wrapping is allowed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (!carry[SCORE_DIGITS] || wrap) begin
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (carry[i]) begin
          value[4*i +: 4] <= (value[4*i +: 4] == BCD_MAX) ? 4'd0 : value[4*i +: 4] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_beat_engine.sv
// Dance-game core: LFSR arrow cues, tempo-timed beats, press judgement,
// BCD score and saturating combo.
module ddr_beat_engine
  import ddr_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int LFSR_W       = 8,
  parameter int TICK_DIV     = 50000,
  parameter int PROG_W       = 16,
  parameter int STEP_BASE    = 80,
  parameter int STEP_DEC     = 20,
  parameter int SCORE_DIGITS = 2,
  parameter int COMBO_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  ddr_beat_engine_if.slave  bus
);

  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PRESC_W = $clog2(TICK_DIV + 1);
  localparam int STEP_W  = $clog2(STEP_BASE + 1);
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  state_t               state_q, state_d;
  logic                 run_q;
  logic [NUM_LANES-1:0] btn_q;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [STEP_W-1:0]    step_q;
  logic [STEP_W-1:0]    step_len_q;
  logic [PROG_W-1:0]    prog_q;
  logic                 verdict_done_q;
  logic                 verdict_hit_q;
  logic [COMBO_W-1:0]   combo_q;

  logic                 tick;
  logic                 step_done;
  logic                 last_step;
  logic                 start_beat;
  logic                 clr_stats;
  logic                 resolve;
  logic                 hit;
  logic                 miss;
  logic [NUM_LANES-1:0] edges;
  logic [NUM_LANES-1:0] lane_mask;
  logic [LANE_W-1:0]    cue_lane;
  logic [STEP_W-1:0]    step_len_new;

  assign cue_lane     = lfsr_q[LANE_W-1:0];
  assign lane_mask    = NUM_LANES'(1) << cue_lane;
  assign edges        = bus.btn & ~btn_q;
  assign tick         = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign step_done    = tick && (step_q == step_len_q - STEP_W'(1));
  assign last_step    = step_done && prog_q[PROG_W-1];
  assign step_len_new = STEP_W'(step_len_calc(int'(bus.level), STEP_BASE, STEP_DEC));

  // A beat with no press, or whose first press pattern was not exactly the cue, is a miss
  assign hit  = resolve && verdict_done_q && verdict_hit_q;
  assign miss = resolve && !(verdict_done_q && verdict_hit_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    start_beat = 1'b0;
    clr_stats  = 1'b0;
    resolve    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run && !run_q) begin
          state_d    = BEAT;
          start_beat = 1'b1;
          clr_stats  = 1'b1;
        end
      end
      BEAT: begin
        if (!bus.run)       state_d = IDLE;
        else if (last_step) state_d = RESOLVE;
      end
      RESOLVE: begin
        resolve = 1'b1;
        if (bus.run) begin
          state_d    = BEAT;
          start_beat = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat timing, progress shifter, press judgement and edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q          <= 1'b0;
      btn_q          <= '0;
      presc_q        <= '0;
      step_q         <= '0;
      step_len_q     <= '0;
      prog_q         <= '0;
      verdict_done_q <= 1'b0;
      verdict_hit_q  <= 1'b0;
    end else begin
      run_q <= bus.run;
      btn_q <= bus.btn;
      if (start_beat) begin
        presc_q        <= '0;
        step_q         <= '0;
        step_len_q     <= step_len_new;
        prog_q         <= PROG_W'(1);
        verdict_done_q <= 1'b0;
        verdict_hit_q  <= 1'b0;
      end else if (state_q == BEAT && bus.run) begin
        presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
        if (tick) step_q <= step_done ? '0 : step_q + STEP_W'(1);
        if (step_done && !prog_q[PROG_W-1]) prog_q <= {prog_q[PROG_W-2:0], 1'b0};
        if (!verdict_done_q && (edges != '0)) begin
          verdict_done_q <= 1'b1;
          verdict_hit_q  <= (edges == lane_mask);
        end
      end else if (state_d == IDLE) begin
        prog_q <= '0;
      end
    end
  end

  // Cue generator: XNOR of the two top taps keeps the all-zero seed moving
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       lfsr_q <= '0;
    else if (resolve) lfsr_q <= {lfsr_q[LFSR_W-2:0], ~(lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2])};
  end

  // Combo: consecutive hits, held at full scale, dropped by any miss
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         combo_q <= '0;
    else if (clr_stats) combo_q <= '0;
    else if (hit)       combo_q <= (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
    else if (miss)      combo_q <= '0;
  end

  ddr_bcd_counter #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (clr_stats),
    .wrap  (1'b1),
    .value (bus.score_bcd)
  );

  assign bus.cue_lane  = cue_lane;
  assign bus.cue_valid = (state_q == BEAT);
  assign bus.prog      = prog_q;
  assign bus.hit       = hit;
  assign bus.miss      = miss;
  assign bus.combo     = combo_q;

endmodule

// File: tb/tb_ddr_beat_engine.sv
// Directed bench for ddr_beat_engine with a short tempo so whole beats fit in a few clocks.
module tb_ddr_beat_engine;

  localparam int NL = 4, PW = 4, SD = 2, CW = 8, TD = 2, SB = 4, SDEC = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] lfsr_m = 8'h00;

  ddr_beat_engine_if #(.NUM_LANES(NL), .PROG_W(PW), .SCORE_DIGITS(SD), .COMBO_W(CW)) bus ();

  ddr_beat_engine #(
    .NUM_LANES(NL), .LFSR_W(8), .TICK_DIV(TD), .PROG_W(PW), .STEP_BASE(SB),
    .STEP_DEC(SDEC), .SCORE_DIGITS(SD), .COMBO_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl_set;  // level driven from the 4th clk of the beat onward
    int         mode;     // 0 none,1 correct,2 wrong,3 correct+wrong,4 correct then wrong,5 wrong then correct
    int         off;      // clk within the beat of the first press
    int         per;      // expected beat period in clk
    logic       hit;
    logic       miss;
    logic [7:0] score;    // after the beat
    logic [7:0] combo;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[6])};
  endfunction

  // Plays one beat from its first clk; ends on the first clk of the following beat.
  task automatic run_beat(input int per_exp, input logic [1:0] lvl_set, input int mode,
                          input int off, output int period, output logic ghit, output logic gmiss);
    logic [3:0] cmask, wmask, b;
    int  k, sc;
    bit  done;
    cmask = 4'b0001 << lfsr_m[1:0];
    wmask = 4'b0001 << (lfsr_m[1:0] ^ 2'd1);
    check("cue_lane", bus.cue_lane, lfsr_m[1:0]);
    check("cue_valid", bus.cue_valid, 1);
    sc = (per_exp - 1) / PW;
    k = 0; done = 0; ghit = 0; gmiss = 0; period = 0;
    while (!done) begin
      if (k == 3) bus.level = lvl_set;
      b = '0;
      case (mode)
        1: if (k == off) b = cmask;
        2: if (k == off) b = wmask;
        3: if (k == off) b = cmask | wmask;
        4: begin if (k == off) b = cmask; if (k == off + 2) b = wmask; end
        5: begin if (k == off) b = wmask; if (k == off + 2) b = cmask; end
        default: ;
      endcase
      bus.btn = b;
      if (bus.hit || bus.miss) begin
        ghit = bus.hit; gmiss = bus.miss; period = k + 1; done = 1;
      end else begin
        if (per_exp > 0 && k < per_exp - 1) check("prog", bus.prog, 4'b0001 << (k / sc));
        if (k >= 200) begin
          n_chk++; n_fail++;
          $display("FAIL beat_timeout: got no pulse after %0d clk, required one", k);
          done = 1;
        end else begin
          step();
          k++;
        end
      end
    end
    lfsr_m = lfsr_next(lfsr_m);
    step();
    check("pulse_once", {bus.hit, bus.miss}, 0);
    check("new_beat_prog", bus.prog, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int   per;
    logic h, m;
    int   bad, pulses;

    tbl[0]  = '{2'd0, 1, 5,  33, 1'b1, 1'b0, 8'h01, 8'd1};
    tbl[1]  = '{2'd0, 0, 0,  33, 1'b0, 1'b1, 8'h01, 8'd0};
    tbl[2]  = '{2'd0, 1, 20, 33, 1'b1, 1'b0, 8'h02, 8'd1};
    tbl[3]  = '{2'd3, 3, 2,  33, 1'b0, 1'b1, 8'h02, 8'd0};
    tbl[4]  = '{2'd3, 4, 1,  9,  1'b1, 1'b0, 8'h03, 8'd1};
    tbl[5]  = '{2'd3, 2, 0,  9,  1'b0, 1'b1, 8'h03, 8'd0};
    tbl[6]  = '{2'd3, 1, 7,  9,  1'b1, 1'b0, 8'h04, 8'd1};
    tbl[7]  = '{2'd3, 1, 8,  9,  1'b0, 1'b1, 8'h04, 8'd0};
    tbl[8]  = '{2'd1, 1, 1,  9,  1'b1, 1'b0, 8'h05, 8'd1};
    tbl[9]  = '{2'd2, 1, 10, 25, 1'b1, 1'b0, 8'h06, 8'd2};
    tbl[10] = '{2'd3, 1, 3,  17, 1'b1, 1'b0, 8'h07, 8'd3};
    tbl[11] = '{2'd3, 5, 1,  9,  1'b0, 1'b1, 8'h07, 8'd0};

    bus.run = 1'b0; bus.level = 2'd0; bus.btn = '0;
    step(); step();
    check("rst_cue_valid", bus.cue_valid, 0);
    check("rst_prog", bus.prog, 0);
    check("rst_hit_miss", {bus.hit, bus.miss}, 0);
    check("rst_score", bus.score_bcd, 0);
    check("rst_combo", bus.combo, 0);
    check("rst_cue_lane", bus.cue_lane, 0);
    reset = 1'b1;
    step(); step();
    check("idle_cue_valid", bus.cue_valid, 0);

    bus.run = 1'b1;
    step();
    check("start_score", bus.score_bcd, 0);
    check("start_combo", bus.combo, 0);
    check("start_prog", bus.prog, 1);

    for (int i = 0; i < 12; i++) begin
      run_beat(tbl[i].per, tbl[i].lvl_set, tbl[i].mode, tbl[i].off, per, h, m);
      check($sformatf("r%0d_period", i), per, tbl[i].per);
      check($sformatf("r%0d_hit", i), h, tbl[i].hit);
      check($sformatf("r%0d_miss", i), m, tbl[i].miss);
      check($sformatf("r%0d_score", i), bus.score_bcd, tbl[i].score);
      check($sformatf("r%0d_combo", i), bus.combo, tbl[i].combo);
    end

    // Asynchronous reset in the middle of a beat with score 07
    step(); step();
    check("pre_rst_cue_valid", bus.cue_valid, 1);
    #3 reset = 1'b0;
    #1;
    check("arst_cue_valid", bus.cue_valid, 0);
    check("arst_prog", bus.prog, 0);
    check("arst_score", bus.score_bcd, 0);
    check("arst_combo", bus.combo, 0);
    check("arst_cue_lane", bus.cue_lane, 0);
    check("arst_hit_miss", {bus.hit, bus.miss}, 0);
    bus.run = 1'b0;
    lfsr_m = 8'h00;
    step(); step();
    reset = 1'b1;
    step(); step();
    check("post_rst_cue_valid", bus.cue_valid, 0);
    check("post_rst_prog", bus.prog, 0);

    // Run dropped mid-beat, then re-raised
    bus.run = 1'b1;
    step();
    run_beat(9, 2'd3, 1, 2, per, h, m);
    check("drop_pre_hit", h, 1);
    check("drop_pre_score", bus.score_bcd, 8'h01);
    step(); step(); step();
    bus.run = 1'b0;
    step();
    check("drop_cue_valid", bus.cue_valid, 0);
    check("drop_prog", bus.prog, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.hit || bus.miss || bus.cue_valid) pulses++;
      step();
    end
    check("drop_no_activity", pulses, 0);
    check("drop_score_held", bus.score_bcd, 8'h01);
    check("drop_combo_held", bus.combo, 1);
    bus.run = 1'b1;
    step();
    check("rerun_cue_valid", bus.cue_valid, 1);
    check("rerun_score", bus.score_bcd, 0);
    check("rerun_combo", bus.combo, 0);
    check("rerun_lfsr_cont", bus.cue_lane, lfsr_m[1:0]);

    // Long hit streak: BCD wrap at 99 and combo saturation at 255
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      run_beat(0, 2'd3, 1, 2, per, h, m);
      if (!h || m || per != 9) bad++;
      if (i == 99) begin
        check("s99_score", bus.score_bcd, 8'h99);
        check("s99_combo", bus.combo, 99);
      end
      if (i == 100) begin
        check("s100_score_wrap", bus.score_bcd, 8'h00);
        check("s100_combo", bus.combo, 100);
      end
      if (i == 255) check("s255_combo", bus.combo, 255);
    end
    check("streak_bad_beats", bad, 0);
    check("s256_combo_sat", bus.combo, 255);
    check("s256_score", bus.score_bcd, 8'h56);
    run_beat(9, 2'd3, 0, 0, per, h, m);
    check("final_miss", m, 1);
    check("final_combo_clr", bus.combo, 0);
    check("final_score_held", bus.score_bcd, 8'h56);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
